// File: rtl/csr_file_m.sv
// csr_file_m: machine-mode CSR file for the NPC core.
//   Handles CSR read/modify/write (RW/RS/RC), trap entry, mret,
//   the timer-interrupt pending flag, and the mcycle/minstret counters.
// Ports:
//   clock, reset_n            rising-edge clock, async active-low reset
//   csr_valid/addr/op/wsrc    CSR access from WB (op: 00 none, 01 RW, 10 RS, 11 RC)
//   csr_rdata, csr_illegal    pre-write value of csr_addr, illegal-access flag
//   trap_valid/cause/pc/tval  trap entry request and its mcause/mepc/mtval data
//   mret, instret, irq_timer  mret retire, retire pulse, timer interrupt level
//   irq_pending               MIE & MTIE & MTIP
//   trap_vector, mret_addr    PC-select targets for trap entry and mret
module csr_file_m #(
  parameter int unsigned     XLEN        = 64,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0,
  parameter logic [XLEN-1:0] HARTID      = '0
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            csr_valid,
  input  logic [11:0]     csr_addr,
  input  logic [1:0]      csr_op,
  input  logic [XLEN-1:0] csr_wsrc,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret,
  input  logic            instret,
  input  logic            irq_timer,
  output logic            irq_pending,
  output logic [XLEN-1:0] trap_vector,
  output logic [XLEN-1:0] mret_addr
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  localparam logic [XLEN-1:0] ONE        = XLEN'(1);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic            st_mie;
  logic            st_mpie;
  logic            mtie;
  logic            mtip;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mscratch;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;
  logic [XLEN-1:0] mtval;
  logic [XLEN-1:0] mcycle;
  logic [XLEN-1:0] minstret;

  logic            addr_known;
  logic            op_active;
  logic            write_do;
  logic            wr_en;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] mtvec_base;

  // Read mux; also tells us whether the address is implemented.
  always_comb begin
    addr_known = 1'b1;
    csr_rdata  = '0;
    case (csr_addr)
      ADDR_MSTATUS:  csr_rdata = XLEN'({2'b11, 3'b000, st_mpie, 3'b000, st_mie, 3'b000});
      ADDR_MIE:      csr_rdata = XLEN'({mtie, 7'b0000000});
      ADDR_MTVEC:    csr_rdata = mtvec;
      ADDR_MSCRATCH: csr_rdata = mscratch;
      ADDR_MEPC:     csr_rdata = mepc;
      ADDR_MCAUSE:   csr_rdata = mcause;
      ADDR_MTVAL:    csr_rdata = mtval;
      ADDR_MIP:      csr_rdata = XLEN'({mtip, 7'b0000000});
      ADDR_MCYCLE:   csr_rdata = mcycle;
      ADDR_MINSTRET: csr_rdata = minstret;
      ADDR_MHARTID:  csr_rdata = HARTID;
      default:       addr_known = 1'b0;
    endcase
  end

  // RS/RC with a zero operand are pure reads, so they never trip the
  // read-only check on the 0xC00-0xFFF range.
  always_comb begin
    op_active   = csr_valid & (csr_op != 2'b00);
    write_do    = (csr_op == OP_RW) | (csr_wsrc != '0);
    csr_illegal = op_active & (~addr_known | ((csr_addr[11:10] == 2'b11) & write_do));
    wr_en       = op_active & write_do & ~csr_illegal;
  end

  always_comb begin
    wdata = csr_rdata;
    case (csr_op)
      OP_RW:   wdata = csr_wsrc;
      OP_RS:   wdata = csr_rdata | csr_wsrc;
      OP_RC:   wdata = csr_rdata & ~csr_wsrc;
      default: wdata = csr_rdata;
    endcase
  end

  // Vectored mode only applies to interrupts; modes 1x fall back to direct.
  always_comb begin
    mtvec_base = {mtvec[XLEN-1:2], 2'b00};
    if ((mtvec[1:0] == 2'b01) && trap_cause[XLEN-1])
      trap_vector = mtvec_base + {trap_cause[XLEN-3:0], 2'b00};
    else
      trap_vector = mtvec_base;
  end

  assign mret_addr   = mepc;
  assign irq_pending = st_mie & mtie & mtip;

  // Counters increment unconditionally first; a later CSR write in the same
  // block overrides the increment. Trap and mret suppress CSR writes entirely.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st_mie   <= 1'b0;
      st_mpie  <= 1'b0;
      mtie     <= 1'b0;
      mtip     <= 1'b0;
      mtvec    <= MTVEC_RESET;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mtval    <= '0;
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      mtip   <= irq_timer;
      mcycle <= mcycle + ONE;
      if (instret)
        minstret <= minstret + ONE;

      if (trap_valid) begin
        mepc    <= trap_pc & ALIGN_MASK;
        mcause  <= trap_cause;
        mtval   <= trap_tval;
        st_mpie <= st_mie;
        st_mie  <= 1'b0;
      end else if (mret) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end else if (wr_en) begin
        case (csr_addr)
          ADDR_MSTATUS: begin
            st_mie  <= wdata[3];
            st_mpie <= wdata[7];
          end
          ADDR_MIE:      mtie     <= wdata[7];
          ADDR_MTVEC:    mtvec    <= wdata;
          ADDR_MSCRATCH: mscratch <= wdata;
          ADDR_MEPC:     mepc     <= wdata & ALIGN_MASK;
          ADDR_MCAUSE:   mcause   <= wdata;
          ADDR_MTVAL:    mtval    <= wdata;
          ADDR_MCYCLE:   mcycle   <= wdata;
          ADDR_MINSTRET: minstret <= wdata;
          default: ;
        endcase
      end
    end
  end

endmodule
